// File: rtl/vga_sync_gen.sv
// VGA sync source: 11-bit h/v pixel counters with hsync, vsync, active and
// frame_start strobes, plus a shadow/live threshold bank loaded per frame.
//
// Ports:
//   clk, rst (sync, active-high), en (pixel enable)
//   cfg_we/cfg_sel/cfg_wdata : shadow threshold write port
//   cfg_rdata                : shadow[cfg_sel], one clk latency
//   hcount, vcount           : current pixel position
//   hsync, vsync, active, frame_start : registered timing strobes
module vga_sync_gen #(
  parameter logic [10:0] H_ACT  = 11'd640,
  parameter logic [10:0] H_SS   = 11'd656,
  parameter logic [10:0] H_SE   = 11'd752,
  parameter logic [10:0] H_LAST = 11'd799,
  parameter logic [10:0] V_ACT  = 11'd480,
  parameter logic [10:0] V_SS   = 11'd490,
  parameter logic [10:0] V_SE   = 11'd492,
  parameter logic [10:0] V_LAST = 11'd524,
  parameter logic        HS_POL = 1'b0,
  parameter logic        VS_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_sel,
  input  logic [10:0] cfg_wdata,
  output logic [10:0] cfg_rdata,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);

  localparam int I_HACT  = 0;
  localparam int I_HSS   = 1;
  localparam int I_HSE   = 2;
  localparam int I_HLAST = 3;
  localparam int I_VACT  = 4;
  localparam int I_VSS   = 5;
  localparam int I_VSE   = 6;
  localparam int I_VLAST = 7;

  localparam logic [7:0][10:0] DEF = {
    V_LAST, V_SE, V_SS, V_ACT,
    H_LAST, H_SE, H_SS, H_ACT
  };

  logic [7:0][10:0] shadow_q, shadow_d;
  logic [7:0][10:0] live_q, live_d;
  logic [10:0]      hcount_q, hcount_d;
  logic [10:0]      vcount_q, vcount_d;
  logic [10:0]      rdata_q, rdata_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;
  logic             fstart_q, fstart_d;
  logic             h_wrap, v_wrap, frame_end;

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) shadow_d[cfg_sel] = cfg_wdata;

    h_wrap    = (hcount_q == live_q[I_HLAST]);
    v_wrap    = (vcount_q == live_q[I_VLAST]);
    frame_end = en && h_wrap && v_wrap;

    // Live bank takes the post-write shadow so a write on the
    // boundary edge lands in the new frame.
    live_d = frame_end ? shadow_d : live_q;

    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (en) begin
      hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
      end
    end

    // Strobes derive from next-state counters and next-state
    // thresholds so they line up with the registered counters.
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    active_d = active_q;
    fstart_d = fstart_q;
    if (en) begin
      if (hcount_d == live_d[I_HSS]) begin
        hsync_d = HS_POL;
      end else if (hcount_d == live_d[I_HSE]) begin
        hsync_d = ~HS_POL;
      end
      if (vcount_d == live_d[I_VSS]) begin
        vsync_d = VS_POL;
      end else if (vcount_d == live_d[I_VSE]) begin
        vsync_d = ~VS_POL;
      end
      active_d = (hcount_d < live_d[I_HACT]) &&
                 (vcount_d < live_d[I_VACT]);
      fstart_d = (hcount_d == 11'd0) &&
                 (vcount_d == 11'd0);
    end

    rdata_d = shadow_q[cfg_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= DEF;
      live_q   <= DEF;
      hcount_q <= H_LAST;
      vcount_q <= V_LAST;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      active_q <= 1'b0;
      fstart_q <= 1'b0;
      rdata_q  <= 11'd0;
    end else begin
      shadow_q <= shadow_d;
      live_q   <= live_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      fstart_q <= fstart_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cfg_rdata   = rdata_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: random/directed stimulus against a
// position-and-window reference model.
module tb_vga_sync_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_sel = 3'd0;
  logic [10:0] cfg_wdata = 11'd0;
  logic [10:0] cfg_rdata, hcount, vcount;
  logic        hsync, vsync, active, frame_start;

  int n_chk = 0;
  int n_fail = 0;

  int DEF [8] = '{640, 656, 752, 799, 480, 490, 492, 524};
  int msh [8];
  int mlv [8];
  int mh, mv, mrd;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync),
    .active(active), .frame_start(frame_start)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Model: pixel position plus window tests on live thresholds.
  task automatic model_step(bit r, bit e, bit we,
                            int sel, int wd);
    if (r) begin
      mh = 799; mv = 524; mrd = 0;
      msh = DEF; mlv = DEF;
    end else begin
      mrd = msh[sel];
      if (we) msh[sel] = wd;
      if (e) begin
        if (mh == mlv[3]) begin
          mh = 0;
          if (mv == mlv[7]) begin
            mv = 0;
            mlv = msh;
          end else mv++;
        end else mh++;
      end
    end
  endtask

  task automatic check_all();
    bit hin, vin;
    hin = (mh >= mlv[1]) && (mh < mlv[2]);
    vin = (mv >= mlv[5]) && (mv < mlv[6]);
    chk("hcount", 32'(hcount), mh);
    chk("vcount", 32'(vcount), mv);
    chk("hsync", 32'(hsync), hin ? 0 : 1);
    chk("vsync", 32'(vsync), vin ? 0 : 1);
    chk("active", 32'(active),
        (mh < mlv[0] && mv < mlv[4]) ? 1 : 0);
    chk("frame_start", 32'(frame_start),
        (mh == 0 && mv == 0) ? 1 : 0);
    chk("cfg_rdata", 32'(cfg_rdata), mrd);
  endtask

  task automatic cycle(bit r, bit e, bit we,
                       int sel, int wd);
    rst = r; en = e; cfg_we = we;
    cfg_sel = 3'(sel); cfg_wdata = 11'(wd);
    @(posedge clk);
    model_step(r, e, we, sel, wd);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 3, 5);
    rst = 1'b0;
  endtask

  initial begin
    int cnt_hs, cnt_fs, cnt_h0, cnt_act, maxh, k;
    bit ok;

    // Reset state
    do_reset();
    chk("rst_hcount", 32'(hcount), 799);
    chk("rst_vcount", 32'(vcount), 524);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_rdata", 32'(cfg_rdata), 0);

    // Continuous run, default timing, three lines
    cnt_hs = 0; cnt_fs = 0; cnt_h0 = 0; cnt_act = 0;
    for (int i = 0; i < 2400; i++) begin
      cycle(0, 1, 0, $urandom_range(0, 7), 0);
      if (hsync == 1'b0) cnt_hs++;
      if (frame_start) cnt_fs++;
      if (hcount == 11'd0) cnt_h0++;
      if (active) cnt_act++;
    end
    chk("def_hsync_low", cnt_hs, 3 * 96);
    chk("def_fstart", cnt_fs, 1);
    chk("def_lines", cnt_h0, 3);
    chk("def_active", cnt_act, 3 * 640);

    // en toggling every clk, then random en
    for (int i = 0; i < 1600; i++)
      cycle(0, i % 2 == 0, 0, $urandom_range(0, 7), 0);
    for (int i = 0; i < 2000; i++)
      cycle(0, $urandom_range(0, 1), 0,
            $urandom_range(0, 7), 0);

    // Pending shadow write then reset at hcount 300
    cycle(0, 0, 1, 3, 123);
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      if (mh == 300) ok = 1;
      else cycle(0, $urandom_range(0, 1), 0, 0, 0);
    end
    chk("wait_h300", ok, 1);
    cycle(1, 1, 1, 1, 7);
    rst = 1'b0;
    chk("mid_rst_h", 32'(hcount), 799);
    chk("mid_rst_v", 32'(vcount), 524);
    chk("mid_rst_act", 32'(active), 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, i, 0);
      chk("rd_default", 32'(cfg_rdata), DEF[i]);
    end

    // Small frame A loaded before first en
    cycle(0, 0, 1, 0, 160); cycle(0, 0, 1, 1, 170);
    cycle(0, 0, 1, 2, 180); cycle(0, 0, 1, 3, 199);
    cycle(0, 0, 1, 4, 30);  cycle(0, 0, 1, 5, 32);
    cycle(0, 0, 1, 6, 34);  cycle(0, 0, 1, 7, 39);
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      if (mv == 10 && mh > 5) ok = 1;
      else cycle(0, $urandom_range(0, 9) < 7, 0,
                 $urandom_range(0, 7), 0);
    end
    chk("wait_v10", ok, 1);

    // Mid-frame rewrite to frame B
    cycle(0, 1, 1, 3, 99); cycle(0, 1, 1, 1, 70);
    cycle(0, 1, 1, 2, 80); cycle(0, 1, 1, 0, 64);
    cycle(0, 1, 0, 3, 0);
    chk("rd_hlast", 32'(cfg_rdata), 99);
    maxh = 0; ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (int'(hcount) > maxh) maxh = int'(hcount);
      if (hcount == 0 && vcount == 0) ok = 1;
    end
    chk("wait_bound", ok, 1);
    chk("old_line_max", maxh, 199);
    maxh = 0; cnt_hs = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (int'(hcount) > maxh) maxh = int'(hcount);
      if (hsync == 1'b0) cnt_hs++;
    end
    chk("new_line_max", maxh, 99);
    chk("new_hsync_low", cnt_hs, 10);
    chk("new_line_wrap_v", 32'(vcount), 1);
    for (int i = 0; i < 4000; i++)
      cycle(0, $urandom_range(0, 1), 0,
            $urandom_range(0, 7), 0);

    // Illegal hsync start beyond line end
    do_reset();
    cycle(0, 0, 1, 1, 900);
    cnt_hs = 0; cnt_h0 = 0; maxh = 0;
    for (int i = 0; i < 2400; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (hsync == 1'b0) cnt_hs++;
      if (hcount == 11'd0) cnt_h0++;
      k = int'(hcount);
      if (k > maxh) maxh = k;
    end
    chk("bad_hsync_low", cnt_hs, 0);
    chk("bad_lines", cnt_h0, 3);
    chk("bad_max_h", maxh, 799);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
